// File: rtl/cpu_control_unit_if.sv
// Instruction-memory fetch handshake between cpu_control_unit and its
// instruction store.
//   imem_addr  control -> memory  8-bit fetch address (the PC)
//   imem_req   control -> memory  fetch request, high for the whole FETCH state
//   imem_ack   memory -> control  data valid this cycle
//   imem_data  memory -> control  16-bit instruction word
interface cpu_control_unit_if;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;

  modport master (output imem_addr, imem_req, input imem_ack, imem_data);
  modport slave  (input imem_addr, imem_req, output imem_ack, imem_data);
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit for register_file_plus_alu.
// Runs IDLE -> FETCH -> DECODE -> EXECUTE -> FETCH ... and stops in HALT on HLT.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start                one-cycle pulse, restarts from PC 0 in IDLE/HALT
//   imem                 fetch handshake (master side)
//   N, Z, V, C           datapath ALU flags (combinational)
//   RF_en, RF_addr       register write strobe / destination
//   read_A, read_B       register read selects
//   add_or_sub, out_imm  ALU mode and immediate-operand select
//   ext_B_data           immediate driven to the datapath
//   LHI, LLI             load-high / load-low immediate selects
//   ctro_outR            load output register from read_A
//   flags                stored {N,Z,V,C}
//   halted, illegal      HALT state / sticky undefined-opcode indicator
module cpu_control_unit (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  cpu_control_unit_if.master        imem,
  input  logic                      N,
  input  logic                      Z,
  input  logic                      V,
  input  logic                      C,
  output logic                      RF_en,
  output logic [2:0]                RF_addr,
  output logic [2:0]                read_A,
  output logic [2:0]                read_B,
  output logic                      add_or_sub,
  output logic                      out_imm,
  output logic [15:0]               ext_B_data,
  output logic                      LHI,
  output logic                      LLI,
  output logic                      ctro_outR,
  output logic [3:0]                flags,
  output logic                      halted,
  output logic                      illegal
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_HALT} state_t;

  localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB  = 5'b00001,
                         OP_ADDI = 5'b00010, OP_SUBI = 5'b00011,
                         OP_LLI  = 5'b00100, OP_LHI  = 5'b00101,
                         OP_OUTR = 5'b00110, OP_CMP  = 5'b00111,
                         OP_B    = 5'b01000, OP_BZ   = 5'b01001,
                         OP_HLT  = 5'b11111;

  state_t      state, state_nxt;
  logic [7:0]  pc;
  logic [15:0] ir;
  // Decoded fields, registered in DECODE and held through EXECUTE.
  logic [4:0]  op;
  logic [2:0]  rd, ra, rb;
  logic [7:0]  imm8;
  logic [15:0] sext5;
  logic        taken, set_flags, undef_op;

  assign sext5     = {{11{imm8[4]}}, imm8[4:0]};
  // BZ looks at the stored Z, i.e. flags from before this instruction.
  assign taken     = (op == OP_B) || (op == OP_BZ && flags[2]);
  assign set_flags = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) ||
                     (op == OP_SUBI) || (op == OP_CMP);
  assign undef_op  = (op > OP_BZ) && (op != OP_HLT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
      S_FETCH:        if (imem.imem_ack) state_nxt = S_DECODE;
      S_DECODE:       state_nxt = S_EXECUTE;
      S_EXECUTE:      state_nxt = (op == OP_HLT) ? S_HALT : S_FETCH;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // PC, IR, decoded fields, flags, sticky illegal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      op      <= '0;
      rd      <= '0;
      ra      <= '0;
      rb      <= '0;
      imm8    <= '0;
      flags   <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: if (start) pc <= '0;
        S_FETCH:        if (imem.imem_ack) ir <= imem.imem_data;
        S_DECODE: begin
          op   <= ir[15:11];
          rd   <= ir[10:8];
          ra   <= ir[7:5];
          rb   <= ir[4:2];
          imm8 <= ir[7:0];
        end
        S_EXECUTE: begin
          if (set_flags) flags <= {N, Z, V, C};
          if (undef_op)  illegal <= 1'b1;
          if (op != OP_HLT) pc <= taken ? pc + 8'd1 + imm8 : pc + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs: everything comes from the state register, so reset drops
  // imem_req and the EXECUTE strobes immediately.
  assign imem.imem_req  = (state == S_FETCH);
  assign imem.imem_addr = pc;
  assign halted         = (state == S_HALT);

  always_comb begin
    RF_en      = 1'b0;
    RF_addr    = '0;
    read_A     = '0;
    read_B     = '0;
    add_or_sub = 1'b0;
    out_imm    = 1'b0;
    ext_B_data = '0;
    LHI        = 1'b0;
    LLI        = 1'b0;
    ctro_outR  = 1'b0;
    if (state == S_EXECUTE) begin
      case (op)
        OP_ADD, OP_SUB: begin
          RF_en = 1'b1; RF_addr = rd; read_A = ra; read_B = rb;
          add_or_sub = (op == OP_SUB);
        end
        OP_ADDI, OP_SUBI: begin
          RF_en = 1'b1; RF_addr = rd; read_A = ra;
          out_imm = 1'b1; ext_B_data = sext5;
          add_or_sub = (op == OP_SUBI);
        end
        OP_LLI: begin
          RF_en = 1'b1; RF_addr = rd; LLI = 1'b1; ext_B_data = {8'h00, imm8};
        end
        // rd is read back so the datapath can keep its low byte.
        OP_LHI: begin
          RF_en = 1'b1; RF_addr = rd; read_A = rd; LHI = 1'b1;
          ext_B_data = {8'h00, imm8};
        end
        OP_OUTR: begin
          read_A = rd; ctro_outR = 1'b1;
        end
        OP_CMP: begin
          read_A = ra; read_B = rb; add_or_sub = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_control_unit.sv
module tb_cpu_control_unit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic N, Z, V, C, RF_en, add_or_sub, out_imm, LHI, LLI, ctro_outR, halted, illegal;
  logic [2:0]  RF_addr, read_A, read_B;
  logic [15:0] ext_B_data;
  logic [3:0]  flags;
  int n_chk = 0, n_fail = 0, cyc = 0;

  cpu_control_unit_if bus();

  cpu_control_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem(bus),
    .N(N), .Z(Z), .V(V), .C(C),
    .RF_en(RF_en), .RF_addr(RF_addr), .read_A(read_A), .read_B(read_B),
    .add_or_sub(add_or_sub), .out_imm(out_imm), .ext_B_data(ext_B_data),
    .LHI(LHI), .LLI(LLI), .ctro_outR(ctro_outR),
    .flags(flags), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {N,Z,V,C,result}; C is carry-out for add, borrow for subtract.
  function automatic logic [19:0] alu(input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic [16:0] w;
    logic [15:0] r;
    logic v, c;
    if (sub) begin
      r = a - b; c = (a < b); v = (a[15] != b[15]) && (r[15] != a[15]);
    end else begin
      w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
      v = (a[15] == b[15]) && (r[15] != a[15]);
    end
    return {r[15], (r == 16'h0), v, c, r};
  endfunction

  // Behavioural register_file_plus_alu driven by the DUT's controls
  logic [15:0] imem [256];
  logic [15:0] dp_rf [8];
  logic [15:0] dp_out, alu_res;
  logic        dp_clr = 1'b1;

  always_comb {N, Z, V, C, alu_res} = alu(dp_rf[read_A], out_imm ? ext_B_data : dp_rf[read_B], add_or_sub);

  always @(posedge clk) begin
    if (dp_clr) begin
      for (int i = 0; i < 8; i++) dp_rf[i] <= '0;
      dp_out <= '0;
    end else begin
      if (RF_en) dp_rf[RF_addr] <= LLI ? {8'h00, ext_B_data[7:0]} :
                                   LHI ? {ext_B_data[7:0], dp_rf[read_A][7:0]} : alu_res;
      if (ctro_outR) dp_out <= dp_rf[read_A];
    end
  end

  // Instruction-level reference model
  logic [15:0] mreg [8];
  logic [15:0] mout;
  logic [3:0]  mflags;
  logic [7:0]  mpc;
  logic        millegal, mhalt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    mflags = '0; millegal = 1'b0; mpc = '0; mhalt = 1'b0;
  endtask

  task automatic exec_model(input logic [15:0] w);
    logic [4:0]  op;
    logic [2:0]  rd, ra, rb;
    logic [15:0] s5;
    logic [7:0]  i8, npc;
    logic [19:0] r;
    op = w[15:11]; rd = w[10:8]; ra = w[7:5]; rb = w[4:2]; i8 = w[7:0];
    s5 = {{11{w[4]}}, w[4:0]};
    npc = mpc + 8'd1;
    r = '0;
    case (op)
      5'd0: begin r = alu(mreg[ra], mreg[rb], 1'b0); mreg[rd] = r[15:0]; mflags = r[19:16]; end
      5'd1: begin r = alu(mreg[ra], mreg[rb], 1'b1); mreg[rd] = r[15:0]; mflags = r[19:16]; end
      5'd2: begin r = alu(mreg[ra], s5, 1'b0);       mreg[rd] = r[15:0]; mflags = r[19:16]; end
      5'd3: begin r = alu(mreg[ra], s5, 1'b1);       mreg[rd] = r[15:0]; mflags = r[19:16]; end
      5'd4: mreg[rd] = {8'h00, i8};
      5'd5: mreg[rd] = {i8, mreg[rd][7:0]};
      5'd6: mout = mreg[rd];
      5'd7: begin r = alu(mreg[ra], mreg[rb], 1'b1); mflags = r[19:16]; end
      5'd8: npc = mpc + 8'd1 + i8;
      5'd9: if (mflags[2]) npc = mpc + 8'd1 + i8;
      5'd31: begin mhalt = 1'b1; npc = mpc; end
      default: millegal = 1'b1;
    endcase
    mpc = npc;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = {5'h1f, 11'h0};
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    reset_model();
  endtask

  // Pulse start, then serve fetches with dmin..dmax wait cycles, checking
  // each step against the model, for up to max_instr instructions.
  task automatic run_prog(input int max_instr, input int dmin, input int dmax);
    int n, d, exp_cyc, c0;
    logic [15:0] w;
    logic [4:0]  op;
    n = 0; exp_cyc = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    mpc = '0; mhalt = 1'b0; c0 = cyc;
    check("halt_clr", halted, 1'b0);
    while (!mhalt && n < max_instr) begin
      d = $urandom_range(dmax, dmin);
      for (int i = 0; i < d; i++) begin
        bus.imem_ack = 1'b0; bus.imem_data = 16'($urandom);
        check("wait_req", bus.imem_req, 1'b1);
        check("wait_addr", bus.imem_addr, mpc);
        check("wait_ctl", {RF_en, ctro_outR, LHI, LLI}, 4'b0);
        @(negedge clk);
      end
      w = imem[mpc]; op = w[15:11];
      bus.imem_ack = 1'b1; bus.imem_data = w;
      check("fetch_req", bus.imem_req, 1'b1);
      check("fetch_addr", bus.imem_addr, mpc);
      @(negedge clk);                                  // DECODE
      bus.imem_ack = 1'($urandom); bus.imem_data = 16'($urandom);
      check("no_b2b_req", bus.imem_req, 1'b0);
      @(negedge clk);                                  // EXECUTE
      bus.imem_ack = 1'b0;
      check("rf_en", RF_en, op <= 5'd5);
      check("outr_strobe", ctro_outR, op == 5'd6);
      exec_model(w);
      exp_cyc += 3 + d;
      @(negedge clk);
      check("req_next", bus.imem_req, !mhalt);
      check("halted", halted, mhalt);
      check("flags", flags, mflags);
      check("illegal", illegal, millegal);
      n++;
    end
    if (mhalt) check("cycles", cyc - c0, exp_cyc);
    for (int i = 0; i < 8; i++) check($sformatf("r%0d", i), dp_rf[i], mreg[i]);
    check("outr", dp_out, mout);
  endtask

  initial begin
    logic [15:0] w;
    int r;
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    mout = '0;
    bus.imem_ack = 1'b0; bus.imem_data = '0;
    reset_model();
    repeat (3) @(negedge clk);
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_addr", bus.imem_addr, 8'h00);
    check("rst_status", {halted, illegal, flags}, 6'b0);
    check("rst_ctl", {RF_en, ctro_outR, LHI, LLI, out_imm, add_or_sub}, 6'b0);
    check("rst_imm", ext_B_data, 16'h0);
    dp_clr = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", bus.imem_req, 1'b0);

    // LLI/LHI/OUTR/HLT, zero-wait memory
    clear_mem();
    imem[0] = {5'd4, 3'd1, 8'h34};
    imem[1] = {5'd5, 3'd1, 8'h12};
    imem[2] = {5'd6, 3'd1, 8'h00};
    run_prog(100, 0, 0);
    check("outr_1234", dp_out, 16'h1234);
    check("hlt_pc", bus.imem_addr, 8'h03);

    // signed overflow on ADD
    clear_mem();
    imem[0] = {5'd4, 3'd2, 8'hFF};
    imem[1] = {5'd5, 3'd2, 8'h7F};
    imem[2] = {5'd4, 3'd3, 8'h01};
    imem[3] = {5'd0, 3'd4, 3'd2, 3'd3, 2'b00};
    run_prog(100, 0, 1);
    check("add_ovf_r4", dp_rf[4], 16'h8000);
    check("add_ovf_flags", flags, 4'b1010);

    // BZ taken after CMP equal
    clear_mem();
    imem[0] = {5'd7, 3'd0, 3'd1, 3'd1, 2'b00};
    imem[1] = {5'd9, 3'd0, 8'h02};
    imem[2] = {5'd4, 3'd7, 8'hEE};
    imem[3] = {5'd4, 3'd7, 8'hEE};
    run_prog(100, 0, 1);
    check("bz_taken_pc", bus.imem_addr, 8'h04);

    // BZ falls through with Z clear
    clear_mem();
    imem[0] = {5'd7, 3'd0, 3'd2, 3'd3, 2'b00};
    imem[1] = {5'd9, 3'd0, 8'h02};
    run_prog(100, 0, 1);
    check("bz_fall_pc", bus.imem_addr, 8'h02);

    // ack delayed 3 cycles on every fetch
    clear_mem();
    imem[0] = {5'd4, 3'd6, 8'h5A};
    run_prog(100, 3, 3);

    // B -1 at 0x00 is a self-loop
    clear_mem();
    imem[0] = {5'd8, 3'd0, 8'hFF};
    run_prog(3, 0, 1);
    do_reset();

    // 0x00 -> 0xFF, then B +0 at 0xFF wraps to 0x00
    clear_mem();
    imem[0]   = {5'd8, 3'd0, 8'hFE};
    imem[255] = {5'd8, 3'd0, 8'h00};
    run_prog(4, 0, 1);
    do_reset();

    // undefined opcode: no write, flags kept, illegal sticky
    clear_mem();
    imem[0] = {5'd7, 3'd0, 3'd2, 3'd3, 2'b00};
    imem[1] = {5'b10101, 3'd0, 8'h00};
    imem[2] = {5'd4, 3'd0, 8'h11};
    run_prog(100, 0, 1);
    check("illegal_sticky", illegal, 1'b1);

    // reset mid-FETCH drops the request at once
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("fetch_req_pre", bus.imem_req, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("rst_fetch_req", bus.imem_req, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    reset_model();
    check("rst_clr_illegal", illegal, 1'b0);

    // reset mid-EXECUTE suppresses the write
    clear_mem();
    imem[0] = {5'd4, 3'd5, 8'h55};
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_data = imem[0];
    @(negedge clk) bus.imem_ack = 1'b0;
    @(negedge clk);
    check("exec_rf_en", RF_en, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("rst_exec_rf_en", RF_en, 1'b0);
    check("rst_exec_req", bus.imem_req, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_no_write", dp_rf[5], mreg[5]);
    check("rst_idle", {bus.imem_req, halted}, 2'b00);
    rst_n = 1'b1;
    reset_model();

    // random forward-only programs with random ack latency
    for (int p = 0; p < 15; p++) begin
      clear_mem();
      for (int a = 0; a < 40; a++) begin
        w = 16'($urandom);
        r = $urandom_range(0, 40);
        if (r <= 9)       w[15:11] = 5'(r);
        else if (r == 40) w[15:11] = 5'(16 + $urandom_range(0, 14));
        else              w[15:11] = 5'(r % 8);
        if (w[15:11] == 5'd8 || w[15:11] == 5'd9) w[7:0] = 8'($urandom_range(0, 3));
        imem[a] = w;
      end
      run_prog(100, 0, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Multi-cycle control unit that fetches 16-bit instructions, decodes them and drives every control input of `register_file_plus_alu`: register selects, write enable, ALU mode, immediate, LHI/LLI and output-register strobe. The datapath's N/Z/V/C outputs feed back into this block for flag storage and conditional branches. This block owns the program counter and the instruction-memory request handshake.

## Interface
- No parameters. Widths are fixed: 16-bit instruction, 8-bit PC, 3-bit register index.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; starts execution from PC 0 when in IDLE or HALT.
- `imem_addr`  out  8  instruction address (= PC).
- `imem_req`  out  1  fetch request.
- `imem_ack`  in  1  fetch data valid this cycle.
- `imem_data`  in  16  instruction word, sampled when `imem_req && imem_ack`.
- `N`, `Z`, `V`, `C`  in  1 each  ALU flags from datapath (combinational).
- `RF_en`  out  1  register-file write enable.
- `RF_addr`  out  3  write destination.
- `read_A`, `read_B`  out  3 each  read selects.
- `add_or_sub`  out  1  0 = add, 1 = subtract.
- `out_imm`  out  1  ALU B operand = `ext_B_data`.
- `ext_B_data`  out  16  immediate to datapath.
- `LHI`, `LLI`  out  1 each  load-high / load-low immediate select.
- `ctro_outR`  out  1  load output register from rA.
- `flags`  out  4  stored {N,Z,V,C}.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  sticky; set on an undefined opcode.

## Operation
- Fields: op = [15:11], rd = [10:8], ra = [7:5], rb = [4:2], imm5 = [4:0] (sign-extended), imm8 = [7:0].
- Opcodes:
  - 00000 ADD: rd = ra + rb.
  - 00001 SUB: rd = ra − rb.
  - 00010 ADDI: rd = ra + sext(imm5).
  - 00011 SUBI: rd = ra − sext(imm5).
  - 00100 LLI: rd = {8'h00, imm8}.
  - 00101 LHI: rd = {imm8, rd[7:0]}; `read_A` = rd.
  - 00110 OUTR: OutR = rd; `read_A` = rd.
  - 00111 CMP: ra − rb, flags only, no write.
  - 01000 B: unconditional branch.
  - 01001 BZ: branch if stored Z = 1.
  - 11111 HLT.
  - Any other opcode: NOP, sets `illegal`.
- States: IDLE, FETCH, DECODE, EXECUTE, HALT. Reset enters IDLE.
- IDLE / HALT: on `start`, PC ← 0, go to FETCH; all other inputs are ignored.
- FETCH: `imem_req` = 1, `imem_addr` = PC. On `imem_ack`, latch IR and go to DECODE. With no ack, stay in FETCH with req held.
- DECODE: one cycle; IR fields registered into control registers.
- EXECUTE: one cycle.
  - Controls are driven for the decoded op.
  - `RF_en` = 1 for ADD/SUB/ADDI/SUBI/LLI/LHI.
  - `ctro_outR` = 1 for OUTR.
  - `flags` ← {N,Z,V,C} at the end of the cycle for ADD/SUB/ADDI/SUBI/CMP only.
  - PC updated, then go to FETCH. HLT goes to HALT instead, and PC is not advanced.
- Control output values:
  - `add_or_sub` = 1 for SUB/SUBI/CMP.
  - `out_imm` = 1 for ADDI/SUBI.
  - `ext_B_data` = sext(imm5) for ADDI/SUBI, {8'h00, imm8} for LLI/LHI, otherwise 0.
  - Outside EXECUTE, `RF_en`, `ctro_outR`, `LHI`, `LLI`, `out_imm` and `add_or_sub` are 0, and the selects are 0.
- PC arithmetic is mod 256.
  - Fall-through: PC + 1. 0xFF wraps to 0x00.
  - Taken branch: PC + 1 + sext(imm8).
  - BZ reads flags stored before this instruction.
- `illegal` clears only on reset.

## Timing
- Reset values: state IDLE, PC 0, IR 0, `flags` 0, every output 0. This includes `imem_req`, `halted` and `illegal`.
- Reset is asynchronous. Asserting `rst_n` low mid-FETCH drops `imem_req` immediately. Asserting it mid-EXECUTE suppresses the `RF_en` pulse immediately.
- Minimum 3 cycles per instruction (ack in the first FETCH cycle). Each wait cycle without ack adds 1.
- `imem_req` deasserts in the cycle after ack; there is no back-to-back request.
- `imem_data` is sampled only on a cycle with `imem_req && imem_ack`. An ack without req is ignored.
- The register write lands at the EXECUTE → FETCH edge. Flag update lands on the same edge.
- An instruction reading a register written by the previous instruction sees the new value; there is no hazard, because writes complete before its DECODE.
- `halted` is asserted from the cycle after the HLT EXECUTE.
- A `start` pulse in HALT clears `halted` in the next cycle.

## Test plan
- Reset, then `start`, with 0-wait memory: LLI r1,0x34; LHI r1,0x12; OUTR r1; HLT → OutR = 0x1234, `halted` = 1 after 12 cycles, PC = 3.
- LLI r2,0xFF; LHI r2,0x7F; LLI r3,0x01; ADD r4,r2,r3 → r4 = 0x8000, `flags` = N1 Z0 V1 C0.
- CMP r1,r1 then BZ +2 → PC skips two words. With Z = 0 stored, BZ falls through. B −1 at PC 0x00 targets 0x00 (self-loop). B +0 at PC 0xFF targets 0x00 (wrap).
- `imem_ack` delayed 3 cycles → `imem_req` held constant with stable `imem_addr`. No control pulse until ack. Total 6 cycles for one instruction.
- Opcode 10101 → no RF write, `flags` unchanged, `illegal` = 1 and persists across later instructions.
- `rst_n` low during an EXECUTE with `RF_en` = 1 → `RF_en` and `imem_req` go low asynchronously, state IDLE, and no register write occurs.
